// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding and funct3 access codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store enables/replication and load shift with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      we,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] shifted;

  always_comb begin
    we    = 4'b1111;
    wdata = store_data;
    shamt = '0;
    case (funct3[1:0])
      2'b00: begin
        we    = 4'b0001 << addr_lo;
        wdata = {(XLEN/8){store_data[7:0]}};
        shamt = {addr_lo, 3'b000};
      end
      2'b01: begin
        we    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {(XLEN/16){store_data[15:0]}};
        shamt = {addr_lo[1], 4'b0000};
      end
      default: ;
    endcase

    // Halfword ignores addr[0] and word ignores addr[1:0], matching the store lanes.
    shifted = rdata >> shamt;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: IDLE/REQ/DONE handshake on the data-memory port.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses skip memory and flag misalign.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            stall,
  output logic            load_valid,
  output logic [XLEN-1:0] load_data,
  output logic            misalign,
  output logic            dm_req,
  output logic [3:0]      dm_we,
  output logic [XLEN-1:0] dm_addr,
  output logic [XLEN-1:0] dm_wdata,
  input  logic            dm_ack,
  input  logic [XLEN-1:0] dm_rdata
);

  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] dm_addr_q, dm_addr_d;
  logic [XLEN-1:0] dm_wdata_q, dm_wdata_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic [3:0]      dm_we_q, dm_we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lo_q, lo_d;
  logic            store_q, store_d;
  logic            err_q, err_d;
  logic [CW-1:0]   wait_q, wait_d;

  logic            start, mis, timeout;
  logic [2:0]      al_f3;
  logic [1:0]      al_lo;
  logic [3:0]      al_we;
  logic [XLEN-1:0] al_wdata, al_ldata;

  assign start = mem_valid & (mem_read | mem_write);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1] && addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign timeout = (MAX_WAIT != 0) && (wait_q == CW'(MAX_WAIT - 1));

  // One aligner serves both paths: live inputs in IDLE, captured access afterwards.
  assign al_f3 = (state_q == IDLE) ? funct3    : f3_q;
  assign al_lo = (state_q == IDLE) ? addr[1:0] : lo_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (al_f3),
    .addr_lo    (al_lo),
    .store_data (store_data),
    .rdata      (dm_rdata),
    .we         (al_we),
    .wdata      (al_wdata),
    .load_data  (al_ldata)
  );

  always_comb begin
    state_d     = state_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    load_data_d = load_data_q;
    dm_we_d     = dm_we_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    store_d     = store_q;
    err_d       = err_q;
    wait_d      = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          f3_d       = funct3;
          lo_d       = addr[1:0];
          store_d    = mem_write;
          dm_addr_d  = {addr[XLEN-1:2], 2'b00};
          dm_wdata_d = al_wdata;
          dm_we_d    = mem_write ? al_we : 4'b0000;
          err_d      = mis;
          if (mis) begin
            dm_we_d = '0;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        wait_d = wait_q + CW'(1);
        if (dm_ack) begin
          state_d = DONE;
          err_d   = 1'b0;
          if (!store_q) load_data_d = al_ldata;
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      load_data_q <= '0;
      dm_we_q     <= '0;
      f3_q        <= '0;
      lo_q        <= '0;
      store_q     <= 1'b0;
      err_q       <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      load_data_q <= load_data_d;
      dm_we_q     <= dm_we_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
      store_q     <= store_d;
      err_q       <= err_d;
      wait_q      <= wait_d;
    end
  end

  assign stall      = (state_q == REQ) || (state_q == IDLE && start);
  assign dm_req     = (state_q == REQ);
  assign load_valid = (state_q == DONE) && !store_q && !err_q;
  assign misalign   = (state_q == DONE) && err_q;
  assign load_data  = load_data_q;
  assign dm_we      = dm_we_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, load scoreboard, corner sequences.
module tb_load_store_unit;

  logic        clk, rst_n;
  logic        mem_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        stall, load_valid, misalign, dm_req;
  logic [31:0] load_data, dm_addr, dm_wdata;
  logic [3:0]  dm_we;

  logic        t_stall, t_load_valid, t_misalign, t_dm_req;
  logic [31:0] t_load_data, t_dm_addr, t_dm_wdata;
  logic [3:0]  t_dm_we;

  load_store_unit #(.XLEN(32), .MAX_WAIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
    .stall(stall), .load_valid(load_valid), .load_data(load_data), .misalign(misalign),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  load_store_unit #(.XLEN(32), .MAX_WAIT(3)) dut_to (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
    .stall(t_stall), .load_valid(t_load_valid), .load_data(t_load_data), .misalign(t_misalign),
    .dm_req(t_dm_req), .dm_we(t_dm_we), .dm_addr(t_dm_addr), .dm_wdata(t_dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_ld = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Load scoreboard: every load_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && load_valid) begin
      if (exp_q.size() == 0) check("unexpected_load_valid", 32'd1, 32'd0);
      else check("load_data", load_data, exp_q.pop_front());
    end
  end

  typedef struct {
    logic        st;
    logic        rd;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdat;
    int unsigned dly;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [31:0] ld;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int unsigned n;
    @(negedge clk);
    mem_valid = 1'b1; mem_read = v.rd; mem_write = v.st;
    funct3 = v.f3; addr = v.a; store_data = v.sd;
    if (!v.st) begin
      exp_q.push_back(v.ld);
      last_ld = v.ld;
    end
    #1;
    check("stall_on_start", {31'd0, stall}, 32'd1);
    check("no_req_in_idle", {31'd0, dm_req}, 32'd0);
    @(negedge clk);
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    check("dm_addr", dm_addr, v.a & 32'hFFFF_FFFC);
    check("dm_we", {28'd0, dm_we}, {28'd0, v.we});
    if (v.st) check("dm_wdata", dm_wdata, v.wd);
    n = 0;
    while (dm_req && n < 40) begin
      n++;
      check("stall_in_req", {31'd0, stall}, 32'd1);
      check("dm_addr_hold", dm_addr, v.a & 32'hFFFF_FFFC);
      dm_ack   = (n > v.dly);
      dm_rdata = dm_ack ? v.rdat : 32'hDEAD_BEEF;
      @(negedge clk);
    end
    dm_ack = 1'b0;
    check("req_cycles", n, v.dly + 1);
    check("stall_done", {31'd0, stall}, 32'd0);
    check("load_valid_done", {31'd0, load_valid}, {31'd0, !v.st});
    check("misalign_done", {31'd0, misalign}, 32'd0);
  endtask

  vec_t vt[13];
  vec_t vm;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        st    rd    f3      addr          sdata         rdata         dly we       wdata         load
    vt[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,        0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h0,         32'h1234_80FF, 0, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vt[2]  = '{1'b0, 1'b1, 3'b100, 32'h0000_2001, 32'h0,         32'h1234_80FF, 0, 4'b0000, 32'h0,        32'h0000_0080};
    vt[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0,         32'h8001_0000, 4, 4'b0000, 32'h0,        32'hFFFF_8001};
    vt[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'hCAFE_BABE, 32'h0,        0, 4'b1111, 32'hCAFE_BABE, 32'h0};
    vt[5]  = '{1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'h0,         32'h1357_2468, 1, 4'b0000, 32'h0,        32'h1357_2468};
    vt[6]  = '{1'b1, 1'b0, 3'b001, 32'h0000_5002, 32'h0000_BEEF, 32'h0,        2, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vt[7]  = '{1'b1, 1'b0, 3'b001, 32'h0000_5000, 32'h1234_BEEF, 32'h0,        0, 4'b0011, 32'hBEEF_BEEF, 32'h0};
    vt[8]  = '{1'b0, 1'b1, 3'b101, 32'h0000_6002, 32'h0,         32'hF00D_1234, 0, 4'b0000, 32'h0,        32'h0000_F00D};
    vt[9]  = '{1'b0, 1'b1, 3'b000, 32'h0000_6000, 32'h0,         32'h0000_007F, 0, 4'b0000, 32'h0,        32'h0000_007F};
    vt[10] = '{1'b0, 1'b1, 3'b000, 32'h0000_6003, 32'h0,         32'h9A00_0000, 0, 4'b0000, 32'h0,        32'hFFFF_FF9A};
    vt[11] = '{1'b1, 1'b0, 3'b000, 32'h0000_7001, 32'h0000_003C, 32'h0,        0, 4'b0010, 32'h3C3C_3C3C, 32'h0};
    vt[12] = '{1'b1, 1'b1, 3'b010, 32'h0000_7100, 32'h0BAD_F00D, 32'h0,        0, 4'b1111, 32'h0BAD_F00D, 32'h0};

    rst_n = 1'b0; mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = '0; addr = '0; store_data = '0; dm_ack = 1'b0; dm_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_dm_req", {31'd0, dm_req}, 32'd0);
    check("rst_dm_we", {28'd0, dm_we}, 32'd0);
    check("rst_load_valid", {31'd0, load_valid}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    rst_n = 1'b1;

    foreach (vt[i]) run_vec(vt[i]);

    // Ack while idle must be ignored; load_data keeps the last load across stores.
    @(negedge clk);
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dm_ack = 1'b0;
    check("idle_ack_no_req", {31'd0, dm_req}, 32'd0);
    check("idle_ack_no_valid", {31'd0, load_valid}, 32'd0);
    check("load_data_hold", load_data, last_ld);

`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    mem_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_3002;
    #1 check("mis_stall_start", {31'd0, stall}, 32'd1);
    @(negedge clk);
    mem_valid = 1'b0; mem_read = 1'b0;
    check("mis_no_req", {31'd0, dm_req}, 32'd0);
    check("mis_flag", {31'd0, misalign}, 32'd1);
    check("mis_no_valid", {31'd0, load_valid}, 32'd0);
    check("mis_stall_rel", {31'd0, stall}, 32'd0);
    @(negedge clk);
    check("mis_pulse_end", {31'd0, misalign}, 32'd0);
    check("mis_no_req_after", {31'd0, dm_req}, 32'd0);
`else
    vm = '{1'b0, 1'b1, 3'b010, 32'h0000_3002, 32'h0, 32'h1122_3344, 0, 4'b0000, 32'h0, 32'h1122_3344};
    run_vec(vm);
`endif

    // Timeout instance gives up after 3 REQ cycles; the unlimited one keeps waiting.
    @(negedge clk);
    mem_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_8000;
    exp_q.push_back(32'h55AA_55AA);
    last_ld = 32'h55AA_55AA;
    @(negedge clk);
    mem_valid = 1'b0; mem_read = 1'b0;
    check("to_req_c1", {31'd0, t_dm_req}, 32'd1);
    @(negedge clk);
    check("to_req_c2", {31'd0, t_dm_req}, 32'd1);
    @(negedge clk);
    check("to_req_c3", {31'd0, t_dm_req}, 32'd1);
    check("to_no_early_flag", {31'd0, t_misalign}, 32'd0);
    @(negedge clk);
    check("to_req_drop", {31'd0, t_dm_req}, 32'd0);
    check("to_misalign", {31'd0, t_misalign}, 32'd1);
    check("to_no_valid", {31'd0, t_load_valid}, 32'd0);
    check("to_stall_rel", {31'd0, t_stall}, 32'd0);
    check("nto_still_req", {31'd0, dm_req}, 32'd1);
    check("nto_no_misalign", {31'd0, misalign}, 32'd0);
    dm_ack = 1'b1; dm_rdata = 32'h55AA_55AA;
    @(negedge clk);
    dm_ack = 1'b0;
    check("nto_done_valid", {31'd0, load_valid}, 32'd1);
    check("to_flag_pulse_end", {31'd0, t_misalign}, 32'd0);
    check("to_late_ack_ignored", {31'd0, t_load_valid}, 32'd0);

    // Reset in the middle of REQ drops the request and yields no result.
    @(negedge clk);
    mem_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_9004;
    @(negedge clk);
    mem_valid = 1'b0; mem_read = 1'b0;
    check("rst_mid_req_up", {31'd0, dm_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req_drop", {31'd0, dm_req}, 32'd0);
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    check("rst_mid_addr", dm_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_valid", {31'd0, load_valid}, 32'd0);
      check("rst_mid_no_req", {31'd0, dm_req}, 32'd0);
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
